// File: rtl/poly_fir_pkg.sv
// -----------------------------------------------------------------------------
// poly_fir_pkg
// Shared constants for the 3x polyphase interpolating FIR: interpolation
// factor, taps per phase, the 21 fixed coefficients and the FSM state type.
// -----------------------------------------------------------------------------
package poly_fir_pkg;

  localparam int L              = 3;
  localparam int TAPS_PER_PHASE = 7;
  localparam int NUM_TAPS       = 21;

  // Widest coefficient magnitude is 253, so 9 bits cover every shift term.
  localparam int COEF_MAG_W     = 9;

  // Coefficient C[n] belongs to phase n % 3, tap n / 3.
  localparam int COEF [NUM_TAPS] = '{
    -32'sd1,   32'sd2,   32'sd8,   32'sd7,  -32'sd9, -32'sd33, -32'sd31,
     32'sd27,  32'sd133, 32'sd229, 32'sd253, 32'sd187, 32'sd77, -32'sd9,
    -32'sd37, -32'sd22,  32'sd1,   32'sd9,   32'sd5,   32'sd0,  -32'sd1
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/poly_interp_phase_mac.sv
// -----------------------------------------------------------------------------
// poly_interp_phase_mac
// Combinational 7-tap dot product of the delay line with the coefficients of
// the selected phase. Every product is built from shifts and adds of the
// sign-extended sample against a constant coefficient; nothing saturates or
// rounds.
// Ports:
//   i_line  : flattened delay line, tap k at bits [k*WI +: WI] (k=0 newest)
//   i_phase : output phase 0..2
//   o_y     : full-precision sum, WORD_SIZE_OUT bits signed
// -----------------------------------------------------------------------------
module poly_interp_phase_mac
  import poly_fir_pkg::*;
#(
  parameter int WORD_SIZE_IN  = 8,
  parameter int WORD_SIZE_OUT = 20
) (
  input  logic [TAPS_PER_PHASE*WORD_SIZE_IN-1:0] i_line,
  input  logic [1:0]                             i_phase,
  output logic signed [WORD_SIZE_OUT-1:0]        o_y
);

  logic signed [WORD_SIZE_OUT-1:0] w_x_ext [TAPS_PER_PHASE];
  logic signed [WORD_SIZE_OUT-1:0] w_sum   [L];

  // Constant-coefficient multiply: add a shifted copy for each set bit of
  // |c|, then negate for negative coefficients.
  function automatic logic signed [WORD_SIZE_OUT-1:0] shift_add_mul(
    input logic signed [WORD_SIZE_OUT-1:0] x,
    input int                              c
  );
    logic signed [WORD_SIZE_OUT-1:0] acc;
    logic [COEF_MAG_W-1:0]           mag;
    acc = '0;
    mag = (c < 0) ? COEF_MAG_W'(-c) : COEF_MAG_W'(c);
    for (int b = 0; b < COEF_MAG_W; b++) begin
      if (mag[b]) begin
        acc = acc + (x <<< b);
      end else begin
        acc = acc;
      end
    end
    return (c < 0) ? -acc : acc;
  endfunction

  // Sign-extend each tap to the output width before any arithmetic.
  always_comb begin
    for (int k = 0; k < TAPS_PER_PHASE; k++) begin
      w_x_ext[k] = {{(WORD_SIZE_OUT-WORD_SIZE_IN){i_line[(k+1)*WORD_SIZE_IN-1]}},
                    i_line[k*WORD_SIZE_IN +: WORD_SIZE_IN]};
    end
  end

  // All three phase sums; each uses only constant coefficients, so the
  // shift-add trees reduce to fixed adders.
  always_comb begin
    for (int p = 0; p < L; p++) begin
      w_sum[p] = '0;
      for (int k = 0; k < TAPS_PER_PHASE; k++) begin
        w_sum[p] = w_sum[p] + shift_add_mul(w_x_ext[k], COEF[p + L*k]);
      end
    end
  end

  // Phase select.
  always_comb begin
    case (i_phase)
      2'd0:    o_y = w_sum[0];
      2'd1:    o_y = w_sum[1];
      2'd2:    o_y = w_sum[2];
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/poly_interp_fir_21.sv
// -----------------------------------------------------------------------------
// poly_interp_fir_21
// 3x interpolating FIR (21 taps, 7 per phase). Each accepted input sample
// produces three outputs, phase 0, 1, 2, on a registered valid/ready stream.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   X, in_valid     : input sample stream, in_ready back to the source
//   Y, out_valid    : registered output sample stream, out_ready from sink
// Timing: the first output of a group is valid the cycle after the accept;
// a new sample is taken in the same cycle phase 2 hands off, so a
// continuous input gives one output per cycle with no gap between groups.
// -----------------------------------------------------------------------------
module poly_interp_fir_21
  import poly_fir_pkg::*;
#(
  parameter int WORD_SIZE_IN  = 8,
  parameter int WORD_SIZE_OUT = 20
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [WORD_SIZE_IN-1:0]  X,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic signed [WORD_SIZE_OUT-1:0] Y,
  output logic                            out_valid,
  input  logic                            out_ready
);

  state_e                          r_state;
  state_e                          w_next_state;
  logic [1:0]                      r_phase;
  logic [1:0]                      w_next_phase;
  logic signed [WORD_SIZE_IN-1:0]  r_line       [TAPS_PER_PHASE];
  logic signed [WORD_SIZE_IN-1:0]  w_shift_line [TAPS_PER_PHASE];
  logic [TAPS_PER_PHASE*WORD_SIZE_IN-1:0] w_mac_line;
  logic [1:0]                      w_mac_phase;
  logic signed [WORD_SIZE_OUT-1:0] w_mac_y;
  logic signed [WORD_SIZE_OUT-1:0] r_y;
  logic                            r_out_valid;
  logic                            w_accept;
  logic                            w_advance;
  logic                            w_in_ready;

  // Next state, next phase and handshake decode. r_phase is the phase of
  // the output currently presented on Y.
  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_EMIT;
          w_next_phase = 2'd0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (r_phase >= 2'd2) begin
            // Last phase handing off: the next sample can enter now.
            w_in_ready = 1'b1;
            if (in_valid) begin
              w_accept     = 1'b1;
              w_next_phase = 2'd0;
            end else begin
              w_next_state = ST_IDLE;
              w_next_phase = 2'd0;
            end
          end else begin
            w_advance    = 1'b1;
            w_next_phase = r_phase + 2'd1;
          end
        end else begin
          w_next_state = ST_EMIT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_phase = 2'd0;
      end
    endcase
  end

  // On accept the MAC sees the line with X already shifted in, so phase 0
  // of the new group can be registered in the accept cycle.
  always_comb begin
    w_shift_line[0] = X;
    for (int k = 1; k < TAPS_PER_PHASE; k++) begin
      w_shift_line[k] = r_line[k-1];
    end
    w_mac_line = '0;
    for (int k = 0; k < TAPS_PER_PHASE; k++) begin
      if (w_accept) begin
        w_mac_line[k*WORD_SIZE_IN +: WORD_SIZE_IN] = w_shift_line[k];
      end else begin
        w_mac_line[k*WORD_SIZE_IN +: WORD_SIZE_IN] = r_line[k];
      end
    end
    w_mac_phase = w_accept ? 2'd0 : (r_phase + 2'd1);
  end

  poly_interp_phase_mac #(
    .WORD_SIZE_IN  (WORD_SIZE_IN),
    .WORD_SIZE_OUT (WORD_SIZE_OUT)
  ) u_mac (
    .i_line  (w_mac_line),
    .i_phase (w_mac_phase),
    .o_y     (w_mac_y)
  );

  // FSM state and phase counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_phase <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
    end
  end

  // Delay line shifts only on an accepted sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS_PER_PHASE; k++) begin
        r_line[k] <= '0;
      end
    end else if (w_accept) begin
      r_line <= w_shift_line;
    end else begin
      r_line <= r_line;
    end
  end

  // Output register: Y loads on every new phase and otherwise holds,
  // including through backpressure and after the group ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_next_state == ST_EMIT);
      if (w_accept || w_advance) begin
        r_y <= w_mac_y;
      end else begin
        r_y <= r_y;
      end
    end
  end

  assign Y         = r_y;
  assign out_valid = r_out_valid;
  assign in_ready  = w_in_ready;

endmodule

// File: tb/tb_poly_interp_fir_21.sv
// -----------------------------------------------------------------------------
// tb_poly_interp_fir_21
// Randomised and directed stimulus against a reference model that keeps the
// last seven accepted samples and queues the three expected outputs of each
// accepted sample using plain integer multiply-accumulate.
// -----------------------------------------------------------------------------
module tb_poly_interp_fir_21;

  localparam int WI = 8;
  localparam int WO = 20;

  logic                 clk;
  logic                 reset;
  logic signed [WI-1:0] X;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [WO-1:0] Y;
  logic                 out_valid;
  logic                 out_ready;

  int n_checks;
  int n_errors;
  int coef [21];
  int hist [7];
  int exp_q [$];
  int rec_q [$];
  int n_acc;
  logic hold_prev;
  int y_prev;

  poly_interp_fir_21 #(
    .WORD_SIZE_IN  (WI),
    .WORD_SIZE_OUT (WO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .X         (X),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 7; k++) hist[k] = 0;
    exp_q.delete();
    hold_prev = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check the presented
  // outputs against the model, then account for the handshakes the coming
  // rising edge will perform.
  task automatic step(input logic iv, input int x, input logic ordy);
    int  exp_y;
    int  s;
    logic acc;
    @(negedge clk);
    in_valid  = iv;
    X         = x[WI-1:0];
    out_ready = ordy;
    #1;
    check_eq("out_valid", int'(out_valid), int'(exp_q.size() > 0));
    check_eq("in_ready", int'(in_ready),
             int'(exp_q.size() == 0 || (exp_q.size() == 1 && ordy)));
    if (hold_prev) check_eq("hold_y", int'(Y), y_prev);
    hold_prev = out_valid && !ordy;
    y_prev    = int'(Y);
    if (out_valid && ordy) begin
      if (exp_q.size() > 0) begin
        exp_y = exp_q.pop_front();
        check_eq("y", int'(Y), exp_y);
      end else begin
        check_eq("y_unexpected_valid", int'(out_valid), 0);
      end
      rec_q.push_back(int'(Y));
    end
    acc = iv && in_ready;
    if (acc) begin
      n_acc++;
      for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      for (int p = 0; p < 3; p++) begin
        s = 0;
        for (int k = 0; k < 7; k++) s += coef[p + 3*k] * hist[k];
        exp_q.push_back(s);
      end
    end
  endtask

  // Present one sample until it is accepted (bounded).
  task automatic feed(input int x);
    int start;
    start = n_acc;
    for (int i = 0; i < 8 && n_acc == start; i++) step(1'b1, x, 1'b1);
    if (n_acc == start) check_eq("feed_timeout", n_acc, start + 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, 0, 1'b1);
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic impulse_test(input string tag);
    rec_q.delete();
    feed(1);
    repeat (7) feed(0);
    drain();
    check_eq({tag, "_len"}, rec_q.size(), 24);
    if (rec_q.size() == 24) begin
      for (int i = 0; i < 21; i++) check_eq({tag, "_coef"}, rec_q[i], coef[i]);
      for (int i = 21; i < 24; i++) check_eq({tag, "_zero"}, rec_q[i], 0);
    end
  endtask

  task automatic dc_test(input string tag, input int x, input int e0, input int e1, input int e2);
    int n;
    rec_q.delete();
    repeat (8) feed(x);
    drain();
    n = rec_q.size();
    check_eq({tag, "_len"}, n, 24);
    if (n >= 3) begin
      check_eq({tag, "_p0"}, rec_q[n-3], e0);
      check_eq({tag, "_p1"}, rec_q[n-2], e1);
      check_eq({tag, "_p2"}, rec_q[n-1], e2);
    end
  endtask

  initial begin
    int n0;
    coef = '{-1, 2, 8, 7, -9, -33, -31, 27, 133, 229, 253, 187, 77, -9,
             -37, -22, 1, 9, 5, 0, -1};
    n_checks  = 0;
    n_errors  = 0;
    n_acc     = 0;
    y_prev    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    X         = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_y", int'(Y), 0);
    reset = 1'b1;
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);

    impulse_test("impulse");
    dc_test("dc_pos", 127, 33528, 33655, 33782);
    dc_test("dc_neg", -128, -33792, -33920, -34048);

    // Backpressure at phase 1: Y/out_valid hold and in_ready stays low.
    feed(5);
    step(1'b0, 0, 1'b1);
    repeat (5) step(1'b1, 9, 1'b0);
    drain();

    // Back-to-back input: one accept every three cycles.
    n0 = n_acc;
    for (int i = 0; i < 30; i++) step(1'b1, int'($urandom_range(255)) - 128, 1'b1);
    check_eq("b2b_accepts", n_acc - n0, 10);
    drain();

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(1)), int'($urandom_range(255)) - 128,
           1'($urandom_range(3) != 0));
    end
    drain();

    // Reset in the middle of a group.
    feed(3);
    step(1'b0, 0, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_y", int'(Y), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    impulse_test("impulse_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
